arp_cache: RTL
==============

Name: arp_cache

Overview:
- Parametrised ARP cache for the Ethernet packet-processing path.
- Stores IP-to-MAC bindings learned from received ARP frames, with per-entry valid bits.
- Refreshes in place when an IP is already present, uses round-robin replacement when full, and has a registered lookup port with hit/miss reporting.
- Sits between the ARP RX parser (update port) and the UDP/IP TX header builder (lookup port).

Parameters:
- DEPTH, 16, number of entries; power of two, 2..64.
- AGE_PRESCALE, 125000000, clk cycles per age tick (1 s at 125 MHz).
- AGE_LIMIT, 300, ticks without refresh before an entry expires; range 1..65535.

Ports:
- clk  in  1  system clock.
- arp_cache_rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous single-cycle clear of all entries.
- upd_valid  in  1  learn request; always accepted (no backpressure).
- upd_ip  in  32  sender IP of the received ARP frame.
- upd_mac  in  48  sender MAC of the received ARP frame.
- lkp_req  in  1  lookup strobe.
- lkp_ip  in  32  IP to resolve.
- lkp_done  out  1  one-cycle pulse; lookup result valid.
- lkp_hit  out  1  1 = resolved, 0 = miss.
- lkp_mac  out  48  resolved MAC; 0 on miss.
- entry_count  out  $clog2(DEPTH+1)  number of valid entries.
- evict_pulse  out  1  one-cycle pulse when a valid entry is overwritten by a different IP.

Behaviour:
- Reset values:
  - All valid bits, IP, MAC and age fields are 0.
  - The round-robin pointer is 0.
  - lkp_done, lkp_hit, lkp_mac, entry_count and evict_pulse are all 0.
- Lookup, latency 1:
  - lkp_req sampled high at edge N gives lkp_done=1 and lkp_hit/lkp_mac valid after edge N+1.
  - A back-to-back lkp_req on every cycle gives one result per cycle.
  - Matching is a parallel compare of lkp_ip against all entries with valid=1.
  - lkp_ip=255.255.255.255 always hits with MAC FF:FF:FF:FF:FF:FF.
  - lkp_ip=0 always misses.
  - lkp_hit, lkp_mac and lkp_done hold 0 when no request is pending.
- Update, applied at the edge that samples upd_valid. Priority order:
  1. upd_ip is 0 or broadcast: ignore.
  2. A valid entry has ip==upd_ip: overwrite the MAC and clear the age; entry_count unchanged.
  3. Otherwise, a free entry exists: write the lowest-index free entry; entry_count+1.
  4. Otherwise, the table is full: overwrite the entry at the round-robin pointer, pulse evict_pulse the next cycle, and advance the pointer (DEPTH-1 wraps to 0). The pointer moves only on eviction.
- Same-cycle update and lookup: the lookup sees pre-update contents, so a same-IP lookup misses or returns the old MAC. The lookup issued the following cycle sees the new contents.
- Flush:
  - Clears all valid bits, sets entry_count to 0 and resets the pointer, on the edge that samples it.
  - An update sampled in the same cycle is discarded.
  - A lookup sampled in the same cycle uses pre-flush contents.
- Uniqueness invariant: an IP never occupies two valid entries.
- Reset mid-operation: everything returns to reset values immediately. In-flight lookup results are lost, and no lkp_done is issued for them.

Optional Feature:
- Macro: ARP_CACHE_AGING_EN.
- With the macro defined:
  - A prescaler generates a one-cycle tick every AGE_PRESCALE cycles.
  - Each valid entry's 16-bit age increments per tick, saturating.
  - When age reaches AGE_LIMIT the entry's valid bit clears on that tick edge and entry_count decrements.
  - An update hit on the entry, at the same edge as the tick, wins: the age clears and the entry stays valid.
  - Expired slots count as free for the update priority rule.
- Without the macro: the age fields and prescaler are absent, and entries persist until flush, reset or eviction.

Decomposition:
- Package arp_pkg:
  - typedefs ip_t [31:0] and mac_t [47:0];
  - struct arp_entry_t {valid, ip, mac, age[15:0]};
  - constants BCAST_IP, BCAST_MAC and NULL_IP.
- Sub-module arp_age_tick: prescale counter that emits a tick pulse; instantiated only under ARP_CACHE_AGING_EN.

Test Plan:
1. Release reset, then lkp_req for 192.168.1.10 -> next cycle lkp_done=1, lkp_hit=0, lkp_mac=0, entry_count=0.
2. Update 192.168.1.10 / 00:0A:35:01:02:03, lookup the following cycle -> hit=1 with that MAC, entry_count=1. Lookup 255.255.255.255 -> hit with FF:FF:FF:FF:FF:FF.
3. Re-update 192.168.1.10 with 00:0A:35:0A:0B:0C -> entry_count stays 1, lookup returns the new MAC, evict_pulse stays 0.
4. DEPTH=4: update .1 to .4, then .5 -> evict_pulse=1, lookup .1 misses and .5 hits. Then update .6 -> .2 is evicted (pointer advanced).
5. Same-cycle update and lookup of new IP 10.0.0.7 -> lookup misses, repeat the lookup one cycle later -> hit. Flush together with an update of 10.0.0.8 -> entry_count=0 and 10.0.0.8 misses.
6. ARP_CACHE_AGING_EN, AGE_PRESCALE=10, AGE_LIMIT=3:
   - Entry written, no refresh -> invalid after the 3rd tick, entry_count decremented.
   - Entry refreshed every 20 cycles -> never expires.

Source files
------------

// File: rtl/arp_pkg.sv
// ARP cache shared types and constants.
// Provides IP/MAC typedefs, the cache entry record and the special addresses
// (broadcast and null) that the lookup and update paths treat specially.
package arp_pkg;

    typedef logic [31:0] ip_t;
    typedef logic [47:0] mac_t;

    typedef struct packed {
        logic        valid;
        ip_t         ip;
        mac_t        mac;
        logic [15:0] age;
    } arp_entry_t;

    localparam ip_t  BCAST_IP  = 32'hFFFF_FFFF;
    localparam mac_t BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam ip_t  NULL_IP   = 32'h0000_0000;

endpackage

// File: rtl/arp_age_tick.sv
// Age prescaler: emits a one-cycle tick every PRESCALE clock cycles.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - one-cycle pulse, high in the last cycle of each PRESCALE period
module arp_age_tick #(
    parameter int unsigned PRESCALE = 125000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntW'(PRESCALE - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arp_cache.sv
// ARP cache: IP-to-MAC bindings learned from the ARP RX parser, resolved for
// the UDP/IP TX header builder.
// Ports:
//   clk, arp_cache_rst_n          - clock, asynchronous active-low reset
//   flush                         - single-cycle clear of all entries
//   upd_valid, upd_ip, upd_mac    - learn request (never back-pressured)
//   lkp_req, lkp_ip               - lookup strobe and IP to resolve
//   lkp_done, lkp_hit, lkp_mac    - registered lookup result, one cycle later
//   entry_count                   - number of valid entries
//   evict_pulse                   - a valid entry was replaced by another IP
// Build option: define ARP_CACHE_AGING_EN to expire entries that have not been
// refreshed for AGE_LIMIT ticks of AGE_PRESCALE cycles each.
module arp_cache #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AGE_PRESCALE = 125000000,
    parameter int unsigned AGE_LIMIT    = 300
) (
    input  logic                       clk,
    input  logic                       arp_cache_rst_n,
    input  logic                       flush,
    input  logic                       upd_valid,
    input  logic [31:0]                upd_ip,
    input  logic [47:0]                upd_mac,
    input  logic                       lkp_req,
    input  logic [31:0]                lkp_ip,
    output logic                       lkp_done,
    output logic                       lkp_hit,
    output logic [47:0]                lkp_mac,
    output logic [$clog2(DEPTH+1)-1:0] entry_count,
    output logic                       evict_pulse
);

    import arp_pkg::*;

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    ip_t              ip_q  [DEPTH];
    ip_t              ip_d  [DEPTH];
    mac_t             mac_q [DEPTH];
    mac_t             mac_d [DEPTH];
    logic [IdxW-1:0]  rr_q, rr_d;
    logic             evict_q, evict_d;
    logic             lkp_done_q, lkp_hit_q;
    mac_t             lkp_mac_q;

    logic             lkp_hit_d;
    mac_t             lkp_mac_d;
    logic             upd_ok;
    logic [DEPTH-1:0] match_vec, free_vec, expire_vec;
    logic [IdxW-1:0]  match_idx, free_idx;

`ifdef ARP_CACHE_AGING_EN
    logic [15:0] age_q [DEPTH];
    logic [15:0] age_d [DEPTH];
    logic        tick;

    arp_age_tick #(
        .PRESCALE(AGE_PRESCALE)
    ) u_age_tick (
        .clk  (clk),
        .rst_n(arp_cache_rst_n),
        .tick (tick)
    );

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            expire_vec[i] = tick && valid_q[i] && ((32'(age_q[i]) + 32'd1) >= AGE_LIMIT);
        end
    end
`else
    assign expire_vec = '0;
`endif

    // Lookup compare against pre-update contents; IPs are unique, so OR-ing
    // the matching MACs selects the single hit.
    always_comb begin
        lkp_hit_d = 1'b0;
        lkp_mac_d = '0;
        if (lkp_ip == BCAST_IP) begin
            lkp_hit_d = 1'b1;
            lkp_mac_d = BCAST_MAC;
        end else if (lkp_ip != NULL_IP) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && (ip_q[i] == lkp_ip)) begin
                    lkp_hit_d = 1'b1;
                    lkp_mac_d = lkp_mac_d | mac_q[i];
                end
            end
        end
    end

    // Match and lowest-free search; an entry expiring this edge counts as free.
    always_comb begin
        upd_ok    = upd_valid && (upd_ip != NULL_IP) && (upd_ip != BCAST_IP);
        match_idx = '0;
        free_idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match_vec[i] = valid_q[i] && (ip_q[i] == upd_ip);
            free_vec[i]  = !valid_q[i] || expire_vec[i];
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (match_vec[i]) match_idx = IdxW'(i);
            if (free_vec[i])  free_idx  = IdxW'(i);
        end
    end

    always_comb begin
        valid_d = valid_q & ~expire_vec;
        ip_d    = ip_q;
        mac_d   = mac_q;
        rr_d    = rr_q;
        evict_d = 1'b0;
`ifdef ARP_CACHE_AGING_EN
        for (int i = 0; i < int'(DEPTH); i++) begin
            age_d[i] = age_q[i];
            if (tick && valid_q[i] && (age_q[i] != 16'hFFFF)) begin
                age_d[i] = age_q[i] + 16'd1;
            end
        end
`endif
        if (flush) begin
            valid_d = '0;
            rr_d    = '0;
        end else if (upd_ok) begin
            if (|match_vec) begin
                // Refresh beats a same-edge expiry.
                valid_d[match_idx] = 1'b1;
                mac_d[match_idx]   = upd_mac;
`ifdef ARP_CACHE_AGING_EN
                age_d[match_idx]   = '0;
`endif
            end else if (|free_vec) begin
                valid_d[free_idx] = 1'b1;
                ip_d[free_idx]    = upd_ip;
                mac_d[free_idx]   = upd_mac;
`ifdef ARP_CACHE_AGING_EN
                age_d[free_idx]   = '0;
`endif
            end else begin
                valid_d[rr_q] = 1'b1;
                ip_d[rr_q]    = upd_ip;
                mac_d[rr_q]   = upd_mac;
`ifdef ARP_CACHE_AGING_EN
                age_d[rr_q]   = '0;
`endif
                evict_d       = 1'b1;
                // DEPTH is a power of two, so the increment wraps naturally.
                rr_d          = rr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arp_cache_rst_n) begin
        if (!arp_cache_rst_n) begin
            valid_q    <= '0;
            rr_q       <= '0;
            evict_q    <= 1'b0;
            lkp_done_q <= 1'b0;
            lkp_hit_q  <= 1'b0;
            lkp_mac_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
`ifdef ARP_CACHE_AGING_EN
                age_q[i] <= '0;
`endif
            end
        end else begin
            valid_q    <= valid_d;
            rr_q       <= rr_d;
            evict_q    <= evict_d;
            lkp_done_q <= lkp_req;
            lkp_hit_q  <= lkp_req && lkp_hit_d;
            lkp_mac_q  <= lkp_req ? lkp_mac_d : '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ip_q[i]  <= ip_d[i];
                mac_q[i] <= mac_d[i];
`ifdef ARP_CACHE_AGING_EN
                age_q[i] <= age_d[i];
`endif
            end
        end
    end

    always_comb begin
        entry_count = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_count = entry_count + CntW'(valid_q[i]);
        end
    end

    assign lkp_done    = lkp_done_q;
    assign lkp_hit     = lkp_hit_q;
    assign lkp_mac     = lkp_mac_q;
    assign evict_pulse = evict_q;

endmodule
